mod_sequencer: RTL and testbench

//  Symbol-rate controller for the modulation/signal selector datapath. Advances a PRBS

---
 rtl/mod_pkg.sv | 25 ++
 rtl/prbs_lfsr.sv | 26 ++
 rtl/mod_sequencer.sv | 129 ++++++++++++
 tb/tb_mod_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mod_pkg.sv
// Shared types and encodings for the modulation sequencer and selector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mod_pkg;

  typedef enum logic {
    COUNT = 1'b0,
    ALIGN = 1'b1
  } seq_state_t;

  // Default PRBS generator: x^5 + x^3 + 1, seeded at 1
  localparam logic [4:0] DEF_LFSR_SEED = 5'b00001;
  localparam logic [4:0] DEF_LFSR_TAPS = 5'b10100;

  // Modulation type encodings (low bits of modulation_selector)
  localparam logic [1:0] MOD_ASK  = 2'b00;
  localparam logic [1:0] MOD_BPSK = 2'b10;

  // Carrier waveform encodings (low bits of signal_select)
  localparam logic [1:0] SIG_SIN    = 2'b00;
  localparam logic [1:0] SIG_TRI    = 2'b01;
  localparam logic [1:0] SIG_SAW    = 2'b10;
  localparam logic [1:0] SIG_SQUARE = 2'b11;

endpackage

// File: rtl/prbs_lfsr.sv
// Fibonacci PRBS LFSR, shifts left with the parity of the tapped bits as new LSB.
// Latency: new state visible 1 clock after advance is sampled high.
// Backpressure: none; holds its state whenever advance is low.
//   clk, reset  : clock and synchronous active-high reset (state <= SEED)
//   advance     : step the register once on this edge
//   state       : current LFSR contents
module prbs_lfsr #(
  parameter int           W    = 5,
  parameter logic [W-1:0] SEED = 5'b00001,
  parameter logic [W-1:0] TAPS = 5'b10100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         advance,
  output logic [W-1:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else if (advance) begin
      state <= {state[W-2:0], ^(state & TAPS)};
    end
  end

endmodule

// File: rtl/mod_sequencer.sv
// Symbol-rate controller: steps a PRBS once per symbol, optionally aligned to carrier wraps.
// Latency: strobe max(period,1) clks after a symbol starts (COUNT), or 1 clk after carrier_wrap (ALIGN).
// Backpressure: one-deep config slot; cfg_ready drops on capture and rises when the slot is applied.
//   sym_period   : clocks per symbol, sampled at every symbol update (0 behaves as 1)
//   carrier_wrap : phase-accumulator wrap pulse, only looked at while aligning
//   cfg_*        : selector config offer; applied on the next symbol update
//   mod_sel/sig_sel/en/sym_strobe/lfsr_state : registered outputs toward mod_select
module mod_sequencer
  import mod_pkg::*;
#(
  parameter int                LFSR_W           = 5,
  parameter logic [LFSR_W-1:0] LFSR_SEED        = DEF_LFSR_SEED,
  parameter logic [LFSR_W-1:0] LFSR_TAPS        = DEF_LFSR_TAPS,
  parameter int                CNT_W            = 32,
  parameter int                ALIGN_TO_CARRIER = 1,
  parameter int                MAX_WAIT         = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  sym_period,
  input  logic              carrier_wrap,
  input  logic              cfg_valid,
  input  logic [3:0]        cfg_mod_sel,
  input  logic [7:0]        cfg_sig_sel,
  output logic              cfg_ready,
  output logic [3:0]        mod_sel,
  output logic [7:0]        sig_sel,
  output logic              en,
  output logic              sym_strobe,
  output logic [LFSR_W-1:0] lfsr_state
);

  localparam int               WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  seq_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  period;
  logic [CNT_W-1:0]  period_m1;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        pend_mod;
  logic [7:0]        pend_sig;
  logic              sym_done;
  logic              upd;

  // A zero period is treated as one clock per symbol
  assign period_m1 = (period == '0) ? '0 : period - CNT_W'(1);
  assign sym_done  = (cnt == period_m1);

  always_comb begin
    upd = 1'b0;
    case (state)
      COUNT: upd = (ALIGN_TO_CARRIER == 0) && sym_done;
      ALIGN: upd = carrier_wrap || (wait_cnt == WAIT_LAST);
    endcase
  end

  prbs_lfsr #(
    .W    (LFSR_W),
    .SEED (LFSR_SEED),
    .TAPS (LFSR_TAPS)
  ) u_prbs (
    .clk     (clk),
    .reset   (reset),
    .advance (upd),
    .state   (lfsr_state)
  );

  // The LFSR is itself a register, so en stays a registered output
  assign en = lfsr_state[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= COUNT;
      cnt        <= '0;
      period     <= sym_period;
      wait_cnt   <= '0;
      sym_strobe <= 1'b0;
      cfg_ready  <= 1'b1;
      pend_mod   <= '0;
      pend_sig   <= '0;
      mod_sel    <= '0;
      sig_sel    <= '0;
    end else begin
      sym_strobe <= upd;

      case (state)
        COUNT: begin
          if (sym_done) begin
            cnt <= '0;
            if (ALIGN_TO_CARRIER != 0) begin
              state    <= ALIGN;
              wait_cnt <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ALIGN: begin
          cnt <= '0;
          if (upd) begin
            state <= COUNT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
      endcase

      // cfg_ready low means the slot holds a config waiting for this boundary
      if (upd) begin
        period <= sym_period;
        if (!cfg_ready) begin
          mod_sel   <= pend_mod;
          sig_sel   <= pend_sig;
          cfg_ready <= 1'b1;
        end
      end

      // Only reachable with an empty slot, so it never collides with the apply above;
      // a capture on an update edge therefore waits for the following update.
      if (cfg_valid && cfg_ready) begin
        pend_mod  <= cfg_mod_sel;
        pend_sig  <= cfg_sig_sel;
        cfg_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mod_sequencer.sv
// Directed bench for mod_sequencer: free-running and carrier-aligned instances.
// Latency: n/a.
// Backpressure: n/a.
module tb_mod_sequencer;
  import mod_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: symbol updates at period end
  logic        a_reset = 1'b1;
  logic [31:0] a_period = 32'd4;
  logic        a_wrap = 1'b0;
  logic        a_cfg_valid = 1'b0;
  logic [3:0]  a_cfg_mod = 4'h0;
  logic [7:0]  a_cfg_sig = 8'h00;
  logic        a_cfg_ready;
  logic [3:0]  a_mod_sel;
  logic [7:0]  a_sig_sel;
  logic        a_en;
  logic        a_strobe;
  logic [4:0]  a_lfsr;

  // Instance B: carrier-aligned, short alignment timeout
  logic        b_reset = 1'b1;
  logic [31:0] b_period = 32'd4;
  logic        b_wrap = 1'b0;
  logic        b_cfg_valid = 1'b0;
  logic [3:0]  b_cfg_mod = 4'h0;
  logic [7:0]  b_cfg_sig = 8'h00;
  logic        b_cfg_ready;
  logic [3:0]  b_mod_sel;
  logic [7:0]  b_sig_sel;
  logic        b_en;
  logic        b_strobe;
  logic [4:0]  b_lfsr;

  mod_sequencer #(.ALIGN_TO_CARRIER(0)) u_a (
    .clk(clk), .reset(a_reset), .sym_period(a_period), .carrier_wrap(a_wrap),
    .cfg_valid(a_cfg_valid), .cfg_mod_sel(a_cfg_mod), .cfg_sig_sel(a_cfg_sig),
    .cfg_ready(a_cfg_ready), .mod_sel(a_mod_sel), .sig_sel(a_sig_sel),
    .en(a_en), .sym_strobe(a_strobe), .lfsr_state(a_lfsr)
  );

  mod_sequencer #(.ALIGN_TO_CARRIER(1), .MAX_WAIT(16)) u_b (
    .clk(clk), .reset(b_reset), .sym_period(b_period), .carrier_wrap(b_wrap),
    .cfg_valid(b_cfg_valid), .cfg_mod_sel(b_cfg_mod), .cfg_sig_sel(b_cfg_sig),
    .cfg_ready(b_cfg_ready), .mod_sel(b_mod_sel), .sig_sel(b_sig_sel),
    .en(b_en), .sym_strobe(b_strobe), .lfsr_state(b_lfsr)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clocks until the selected instance strobes, bounded
  task automatic wait_strobe(input bit sel_b, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(sel_b ? b_strobe : a_strobe) && n < 200);
  endtask

  logic [4:0] lfsr_exp [5];
  logic       en_exp   [5];
  int n;
  int total;
  bit seen;

  initial begin
    lfsr_exp = '{5'b00010, 5'b00100, 5'b01001, 5'b10010, 5'b00101};
    en_exp   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // ---------------- instance A: reset state ----------------
    tick(); tick();
    check("a_rst_strobe", a_strobe, 0);
    check("a_rst_en", a_en, 1);
    check("a_rst_lfsr", a_lfsr, 5'b00001);
    check("a_rst_ready", a_cfg_ready, 1);
    check("a_rst_mod", a_mod_sel, 0);
    check("a_rst_sig", a_sig_sel, 0);

    // ---------------- A: strobe every 4, PRBS sequence ----------------
    a_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_strobe(1'b0, n);
      check($sformatf("a_gap%0d", i + 1), n, 4);
      check($sformatf("a_lfsr%0d", i + 1), a_lfsr, lfsr_exp[i]);
      check($sformatf("a_en%0d", i + 1), a_en, en_exp[i]);
    end
    total = 0;
    for (int i = 5; i < 31; i++) begin
      wait_strobe(1'b0, n);
      total += n;
    end
    check("a_gap_26sym", total, 26 * 4);
    check("a_lfsr_wrap31", a_lfsr, 5'b00001);

    // ---------------- A: config mid-symbol, second offer ignored ----------------
    tick();                                  // cnt = 1
    a_cfg_valid = 1'b1; a_cfg_mod = 4'b0010; a_cfg_sig = 8'h01;
    tick();                                  // captured
    check("cfg_ready_low", a_cfg_ready, 0);
    check("cfg_mod_hold", a_mod_sel, 0);
    a_cfg_mod = 4'hF; a_cfg_sig = 8'hAA;
    tick();                                  // offered while busy
    check("cfg_busy_ready", a_cfg_ready, 0);
    check("cfg_busy_strobe", a_strobe, 0);
    a_cfg_valid = 1'b0;
    tick();                                  // symbol boundary
    check("cfg_apply_strobe", a_strobe, 1);
    check("cfg_apply_mod", a_mod_sel, 4'b0010);
    check("cfg_apply_sig", a_sig_sel, 8'h01);
    check("cfg_apply_ready", a_cfg_ready, 1);

    // ---------------- A: capture on the update edge waits one symbol ----------------
    tick(); tick(); tick();                  // cnt = 3
    a_cfg_valid = 1'b1; a_cfg_mod = 4'h3; a_cfg_sig = 8'h05;
    tick();                                  // update and capture together
    a_cfg_valid = 1'b0;
    check("edge_strobe", a_strobe, 1);
    check("edge_mod_old", a_mod_sel, 4'b0010);
    check("edge_sig_old", a_sig_sel, 8'h01);
    check("edge_ready_low", a_cfg_ready, 0);
    wait_strobe(1'b0, n);
    check("edge_gap", n, 4);
    check("edge_mod_new", a_mod_sel, 4'h3);
    check("edge_sig_new", a_sig_sel, 8'h05);
    check("edge_ready_high", a_cfg_ready, 1);

    // ---------------- A: period 0 -> strobe every clock ----------------
    a_period = 32'd0;                        // taken at the next update
    wait_strobe(1'b0, n);
    check("p0_latch_gap", n, 4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("p0_strobe%0d", i), a_strobe, 1);
    end

    // ---------------- instance B: alignment timeout ----------------
    a_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    wait_strobe(1'b1, n);
    check("b_timeout_gap", n, 20);           // 4 COUNT clks + 16 ALIGN clks
    check("b_timeout_lfsr", b_lfsr, 5'b00010);

    // ---------------- B: wrap in COUNT ignored, wrap in ALIGN updates ----------------
    b_wrap = 1'b1;
    tick();                                  // COUNT, cnt -> 1
    b_wrap = 1'b0;
    check("b_wrap_count_ign", b_strobe, 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin        // reach ALIGN and sit there
      tick();
      seen |= b_strobe;
    end
    check("b_no_wrap_no_strobe", seen, 0);
    check("b_lfsr_hold", b_lfsr, 5'b00010);
    b_wrap = 1'b1;
    tick();
    b_wrap = 1'b0;
    check("b_wrap_strobe", b_strobe, 1);
    check("b_wrap_lfsr", b_lfsr, 5'b00100);

    // ---------------- B: wrap every 10 clocks ----------------
    for (int k = 0; k < 3; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 9; i++) begin
        tick();
        seen |= b_strobe;
      end
      b_wrap = 1'b1;
      tick();
      b_wrap = 1'b0;
      check($sformatf("b_per_quiet%0d", k), seen, 0);
      check($sformatf("b_per_strobe%0d", k), b_strobe, 1);
    end
    check("b_per_lfsr", b_lfsr, 5'b00101);

    // ---------------- B: reset while aligning with a pending config ----------------
    b_cfg_valid = 1'b1; b_cfg_mod = 4'h9; b_cfg_sig = 8'h33;
    tick();
    b_cfg_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();      // now in ALIGN
    check("b_pend_ready", b_cfg_ready, 0);
    b_reset = 1'b1;
    tick();
    check("b_rst_strobe", b_strobe, 0);
    check("b_rst_lfsr", b_lfsr, 5'b00001);
    check("b_rst_en", b_en, 1);
    check("b_rst_mod", b_mod_sel, 0);
    check("b_rst_sig", b_sig_sel, 0);
    check("b_rst_ready", b_cfg_ready, 1);
    b_reset = 1'b0;
    wait_strobe(1'b1, n);
    check("b_rst_gap", n, 20);
    check("b_rst_discard_mod", b_mod_sel, 0);
    check("b_rst_discard_sig", b_sig_sel, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
